// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared defaults and helpers for the two-write-port register file.
// Revision : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int DEPTH_DEF    = 32;
    localparam int MAX_PEND_DEF = 4;
    localparam int R0           = 0;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Per-register busy bits, pending counter, full flag and issue ack.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int MAX_PEND = MAX_PEND_DEF,
    parameter int AW       = addr_w(DEPTH),
    parameter int PW       = $clog2(MAX_PEND + 1)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_rd,
    input  logic             web,
    input  logic [AW-1:0]    wb,
    output logic [DEPTH-1:0] sb,
    output logic             iss_ack,
    output logic             sb_full,
    output logic [PW-1:0]    pend
);

    logic [DEPTH-1:0] sb_q,   sb_d;
    logic [PW-1:0]    pend_q, pend_d;
    logic             full_q, full_d;
    logic [DEPTH-1:0] set_v,  clr_v;

    always_comb begin
        iss_ack = iss_en && (iss_rd != AW'(R0)) && !full_q && !sb_q[iss_rd];
        set_v   = '0;
        clr_v   = '0;
        if (iss_ack) begin
            set_v[iss_rd] = 1'b1;
        end
        // Only a write-back to a register that is actually busy frees a slot.
        if (web && (wb != AW'(R0)) && sb_q[wb]) begin
            clr_v[wb] = 1'b1;
        end
        sb_d   = (sb_q & ~clr_v) | set_v;
        pend_d = pend_q + PW'(|set_v) - PW'(|clr_v);
        full_d = (pend_d == PW'(MAX_PEND));
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sb_q   <= '0;
            pend_q <= '0;
            full_q <= 1'b0;
        end else begin
            sb_q   <= sb_d;
            pend_q <= pend_d;
            full_q <= full_d;
        end
    end

    assign sb      = sb_q;
    assign sb_full = full_q;
    assign pend    = pend_q;

endmodule

`default_nettype wire

// File: rtl/regfile_2w_sb.sv
// ============================================================================
// Module   : regfile_2w_sb
// Purpose  : GPR file with ALU/load write ports, bypassed reads, scoreboard
//            and two debug taps.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_2w_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AW       = addr_w(DEPTH),
    parameter int MAX_PEND = MAX_PEND_DEF,
    parameter int TAP0     = 5,
    parameter int TAP1     = 4,
    parameter int PW       = $clog2(MAX_PEND + 1)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [AW-1:0]    ra1,
    output logic [WIDTH-1:0] rd1,
    output logic             busy1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd2,
    output logic             busy2,
    input  logic             wea,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wda,
    input  logic             web,
    input  logic [AW-1:0]    wb,
    input  logic [WIDTH-1:0] wdb,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_rd,
    output logic             iss_ack,
    output logic             sb_full,
    output logic [PW-1:0]    pend,
    output logic [WIDTH-1:0] tap0,
    output logic [WIDTH-1:0] tap1
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] sb;

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .MAX_PEND (MAX_PEND),
        .AW       (AW),
        .PW       (PW)
    ) u_sb (
        .clk     (clk),
        .clrn    (clrn),
        .iss_en  (iss_en),
        .iss_rd  (iss_rd),
        .web     (web),
        .wb      (wb),
        .sb      (sb),
        .iss_ack (iss_ack),
        .sb_full (sb_full),
        .pend    (pend)
    );

    // Port B is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (wea && (wa != AW'(R0))) begin
            regs_d[wa] = wda;
        end
        if (web && (wb != AW'(R0))) begin
            regs_d[wb] = wdb;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd1 = regs_q[ra1];
        if (ra1 == AW'(R0))           rd1 = '0;
        else if (web && (wb == ra1))  rd1 = wdb;
        else if (wea && (wa == ra1))  rd1 = wda;
    end

    always_comb begin
        rd2 = regs_q[ra2];
        if (ra2 == AW'(R0))           rd2 = '0;
        else if (web && (wb == ra2))  rd2 = wdb;
        else if (wea && (wa == ra2))  rd2 = wda;
    end

    // Decode sees a same-cycle load write-back as already complete.
    assign busy1 = sb[ra1] && !(web && (wb == ra1));
    assign busy2 = sb[ra2] && !(web && (wb == ra2));

    assign tap0 = regs_q[TAP0];
    assign tap1 = regs_q[TAP1];

endmodule

`default_nettype wire

// File: tb/tb_regfile_2w_sb.sv
// ============================================================================
// Module   : tb_regfile_2w_sb
// Purpose  : Directed scenarios plus random traffic against a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_2w_sb;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 32;
    localparam int AW       = 5;
    localparam int MAX_PEND = 4;
    localparam int PW       = 3;

    logic             clk  = 1'b0;
    logic             clrn = 1'b0;
    logic [AW-1:0]    ra1, ra2, wa, wb, iss_rd;
    logic             wea, web, iss_en;
    logic [WIDTH-1:0] wda, wdb;
    logic [WIDTH-1:0] rd1, rd2, tap0, tap1;
    logic             busy1, busy2, iss_ack, sb_full;
    logic [PW-1:0]    pend;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0] m_mem  [DEPTH];
    bit               m_busy [DEPTH];
    int               m_pend;

    regfile_2w_sb #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_PEND(MAX_PEND), .TAP0(5), .TAP1(4)
    ) dut (
        .clk(clk), .clrn(clrn),
        .ra1(ra1), .rd1(rd1), .busy1(busy1),
        .ra2(ra2), .rd2(rd2), .busy2(busy2),
        .wea(wea), .wa(wa), .wda(wda),
        .web(web), .wb(wb), .wdb(wdb),
        .iss_en(iss_en), .iss_rd(iss_rd), .iss_ack(iss_ack),
        .sb_full(sb_full), .pend(pend), .tap0(tap0), .tap1(tap1)
    );

    always #5 clk = ~clk;

    // Reference model: architectural registers, busy set and pending count.
    function automatic logic [WIDTH-1:0] m_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (web && wb == a) return wdb;
        if (wea && wa == a) return wda;
        return m_mem[a];
    endfunction

    function automatic logic m_busy_out(input logic [AW-1:0] a);
        return (a != 0) && m_busy[a] && !(web && wb == a);
    endfunction

    function automatic logic m_ack();
        return iss_en && (iss_rd != 0) && (m_pend < MAX_PEND) && !m_busy[iss_rd];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_pend = 0;
    endtask

    task automatic model_commit();
        logic ack;
        ack = m_ack();
        if (web && wb != 0 && m_busy[wb]) begin
            m_busy[wb] = 1'b0;
            m_pend--;
        end
        if (ack) begin
            m_busy[iss_rd] = 1'b1;
            m_pend++;
        end
        if (wea && wa != 0) m_mem[wa] = wda;
        if (web && wb != 0) m_mem[wb] = wdb;
    endtask

    task automatic idle();
        wea = 0; web = 0; iss_en = 0;
        wa = 0; wb = 0; iss_rd = 0; ra1 = 0; ra2 = 0;
        wda = '0; wdb = '0;
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        clrn = 1'b0;
        model_reset();
        #2;
        clrn = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        ra1 = 5;
        #3;
        n_checks++; if (pend !== 3'd0) $display("FAIL reset_pend got=%0d exp=0", pend); else n_pass++;
        n_checks++; if (sb_full !== 1'b0) $display("FAIL reset_full got=%0b exp=0", sb_full); else n_pass++;
        clrn = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 7; i++) begin
            wea = 1; wa = AW'(i); wda = 32'h100 + i;
            iss_en = (i <= 3); iss_rd = AW'(i);
            tick();
        end
        idle();
        #1;
        n_checks++; if (pend !== 3'd3) $display("FAIL prefill_pend got=%0d exp=3", pend); else n_pass++;
        n_checks++; if (tap0 !== 32'h105) $display("FAIL prefill_tap0 got=%h exp=00000105", tap0); else n_pass++;
        ra1 = 3; ra2 = 7;
        clrn = 1'b0;
        model_reset();
        #1;
        n_checks++; if (rd1 !== '0) $display("FAIL midreset_rd1 got=%h exp=0", rd1); else n_pass++;
        n_checks++; if (rd2 !== '0) $display("FAIL midreset_rd2 got=%h exp=0", rd2); else n_pass++;
        n_checks++; if (tap0 !== '0 || tap1 !== '0) $display("FAIL midreset_taps got=%h/%h exp=0/0", tap0, tap1); else n_pass++;
        n_checks++; if (pend !== 3'd0) $display("FAIL midreset_pend got=%0d exp=0", pend); else n_pass++;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL midreset_busy1 got=%0b exp=0", busy1); else n_pass++;
        clrn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_bypass();
        do_reset();
        wea = 1; wa = 3; wda = 32'hDEAD; ra1 = 3;
        #1;
        n_checks++; if (rd1 !== 32'hDEAD) $display("FAIL bypass_a got=%h exp=0000dead", rd1); else n_pass++;
        web = 1; wb = 3; wdb = 32'hBEEF;
        #1;
        n_checks++; if (rd1 !== 32'hBEEF) $display("FAIL bypass_b_wins got=%h exp=0000beef", rd1); else n_pass++;
        tick();
        idle(); ra1 = 3;
        #1;
        n_checks++; if (rd1 !== 32'hBEEF) $display("FAIL stored_b got=%h exp=0000beef", rd1); else n_pass++;
    endtask

    task automatic test_scoreboard();
        do_reset();
        iss_en = 1; iss_rd = 8;
        #1;
        n_checks++; if (iss_ack !== 1'b1) $display("FAIL sb_issue_ack got=%0b exp=1", iss_ack); else n_pass++;
        tick();
        idle(); ra1 = 8;
        #1;
        n_checks++; if (busy1 !== 1'b1) $display("FAIL sb_busy got=%0b exp=1", busy1); else n_pass++;
        n_checks++; if (pend !== 3'd1) $display("FAIL sb_pend1 got=%0d exp=1", pend); else n_pass++;
        web = 1; wb = 8; wdb = 32'h8888;
        #1;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL sb_sameclr got=%0b exp=0", busy1); else n_pass++;
        tick();
        idle(); ra1 = 8;
        #1;
        n_checks++; if (pend !== 3'd0) $display("FAIL sb_pend0 got=%0d exp=0", pend); else n_pass++;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL sb_cleared got=%0b exp=0", busy1); else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            iss_en = 1; iss_rd = AW'(i);
            #1;
            n_checks++; if (iss_ack !== 1'b1) $display("FAIL full_fill_ack r%0d got=%0b exp=1", i, iss_ack); else n_pass++;
            tick();
        end
        iss_en = 1; iss_rd = 5;
        #1;
        n_checks++; if (sb_full !== 1'b1) $display("FAIL full_flag got=%0b exp=1", sb_full); else n_pass++;
        n_checks++; if (iss_ack !== 1'b0) $display("FAIL full_refuse got=%0b exp=0", iss_ack); else n_pass++;
        tick();
        n_checks++; if (pend !== 3'd4) $display("FAIL full_pend_hold got=%0d exp=4", pend); else n_pass++;
        web = 1; wb = 2; wdb = 32'h2222;
        #1;
        n_checks++; if (iss_ack !== 1'b0) $display("FAIL full_sameclr_ack got=%0b exp=0", iss_ack); else n_pass++;
        tick();
        web = 0;
        #1;
        n_checks++; if (sb_full !== 1'b0) $display("FAIL full_freed got=%0b exp=0", sb_full); else n_pass++;
        n_checks++; if (iss_ack !== 1'b1) $display("FAIL full_r5_ack got=%0b exp=1", iss_ack); else n_pass++;
        tick();
        idle();
        #1;
        n_checks++; if (pend !== 3'd4 || sb_full !== 1'b1) $display("FAIL full_refill got=%0d/%0b exp=4/1", pend, sb_full); else n_pass++;
    endtask

    task automatic test_set_wins();
        do_reset();
        iss_en = 1; iss_rd = 6;
        tick();
        web = 1; wb = 6; wdb = 32'h6666; ra1 = 6;
        #1;
        n_checks++; if (iss_ack !== 1'b0) $display("FAIL setwins_busy_refuse got=%0b exp=0", iss_ack); else n_pass++;
        tick();
        #1;
        n_checks++; if (iss_ack !== 1'b1) $display("FAIL setwins_reissue_ack got=%0b exp=1", iss_ack); else n_pass++;
        tick();
        idle(); ra1 = 6;
        #1;
        n_checks++; if (busy1 !== 1'b1) $display("FAIL setwins_busy got=%0b exp=1", busy1); else n_pass++;
        n_checks++; if (pend !== 3'd1) $display("FAIL setwins_pend got=%0d exp=1", pend); else n_pass++;
    endtask

    task automatic test_r0();
        do_reset();
        wea = 1; wa = 0; wda = 32'hFFFF_FFFF;
        web = 1; wb = 0; wdb = 32'hFFFF_FFFF;
        iss_en = 1; iss_rd = 0; ra1 = 0;
        #1;
        n_checks++; if (rd1 !== '0) $display("FAIL r0_rd got=%h exp=0", rd1); else n_pass++;
        n_checks++; if (iss_ack !== 1'b0) $display("FAIL r0_ack got=%0b exp=0", iss_ack); else n_pass++;
        tick();
        idle();
        #1;
        n_checks++; if (rd1 !== '0 || busy1 !== 1'b0 || pend !== 3'd0) $display("FAIL r0_after got=%h/%0b/%0d exp=0/0/0", rd1, busy1, pend); else n_pass++;
        wea = 1; wa = 5; wda = 32'h5555;
        web = 1; wb = 4; wdb = 32'h4444;
        #1;
        n_checks++; if (tap0 !== '0) $display("FAIL tap0_nobypass got=%h exp=0", tap0); else n_pass++;
        tick();
        idle();
        #1;
        n_checks++; if (tap0 !== 32'h5555 || tap1 !== 32'h4444) $display("FAIL taps got=%h/%h exp=00005555/00004444", tap0, tap1); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            ra1    = AW'($urandom_range(0, 9));
            ra2    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 9));
            wea    = $urandom_range(0, 1);
            wa     = AW'($urandom_range(0, 9));
            wda    = $urandom;
            web    = ($urandom_range(0, 9) < 4);
            wb     = AW'($urandom_range(0, 9));
            wdb    = $urandom;
            iss_en = $urandom_range(0, 1);
            iss_rd = AW'($urandom_range(0, 9));
            #1;
            n_checks++; if (rd1 !== m_rd(ra1)) $display("FAIL rnd_rd1 c=%0d got=%h exp=%h", c, rd1, m_rd(ra1)); else n_pass++;
            n_checks++; if (rd2 !== m_rd(ra2)) $display("FAIL rnd_rd2 c=%0d got=%h exp=%h", c, rd2, m_rd(ra2)); else n_pass++;
            n_checks++; if (busy1 !== m_busy_out(ra1)) $display("FAIL rnd_busy1 c=%0d got=%0b exp=%0b", c, busy1, m_busy_out(ra1)); else n_pass++;
            n_checks++; if (busy2 !== m_busy_out(ra2)) $display("FAIL rnd_busy2 c=%0d got=%0b exp=%0b", c, busy2, m_busy_out(ra2)); else n_pass++;
            n_checks++; if (iss_ack !== m_ack()) $display("FAIL rnd_ack c=%0d got=%0b exp=%0b", c, iss_ack, m_ack()); else n_pass++;
            n_checks++; if (pend !== PW'(m_pend)) $display("FAIL rnd_pend c=%0d got=%0d exp=%0d", c, pend, m_pend); else n_pass++;
            n_checks++; if (sb_full !== (m_pend == MAX_PEND)) $display("FAIL rnd_full c=%0d got=%0b exp=%0b", c, sb_full, (m_pend == MAX_PEND)); else n_pass++;
            n_checks++; if (tap0 !== m_mem[5] || tap1 !== m_mem[4]) $display("FAIL rnd_taps c=%0d got=%h/%h exp=%h/%h", c, tap0, tap1, m_mem[5], m_mem[4]); else n_pass++;
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_scoreboard();
        test_full();
        test_set_wins();
        test_r0();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
